// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access-size encodings, FSM state
// type and small lane helpers used by the datapath.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // Encoding 11 is an alias for a full word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) begin
            bad = addr_lo[0];
        end else if (is_word(size)) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

    // Replace one byte or half lane of old_word with the right-justified store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0: merged[7:0]   = data[7:0];
                    2'd1: merged[15:8]  = data[7:0];
                    2'd2: merged[23:16] = data[7:0];
                    default: merged[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[31:16] = data[15:0];
                end else begin
                    merged[15:0] = data[15:0];
                end
            end
            default: merged = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the byte or half lane out of a memory word and
// sign- or zero-extends it to 32 bits; word accesses pass through unchanged.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (size)
            SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit for a word-wide memory; sub-word stores use read-modify-write.
// Optional misaligned-access trap is enabled by defining MEM_ACCESS_MISALIGN_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [31:0]       mem_readData
);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_ext_q, sign_ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       load_result;
`ifdef MEM_ACCESS_MISALIGN_EN
    logic              misalign_q, misalign_d;
`endif

    load_extend u_load_extend (
        .word     (mem_readData),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .sign_ext (sign_ext_q),
        .result   (load_result)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        merge_d    = merge_q;
`ifdef MEM_ACCESS_MISALIGN_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    // Only full-word stores can skip the read of the old word.
                    if (we && is_word(size)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
`ifdef MEM_ACCESS_MISALIGN_EN
                    misalign_d = is_misaligned(size, addr[1:0]);
                    if (misalign_d) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_RD: begin
                if (we_q) begin
                    merge_d = merge_lane(mem_readData, wdata_q, size_q, addr_q[1:0]);
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_result;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            merge_q    <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            merge_q    <= merge_d;
`ifdef MEM_ACCESS_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign ready         = (state_q == ST_IDLE);
    assign done          = (state_q == ST_RESP);
    assign rdata         = rdata_q;
    assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_MemRead   = (state_q == ST_RD);
    assign mem_MemWrite  = (state_q == ST_WR);
    assign mem_writeData = is_word(size_q) ? wdata_q : merge_q;
`ifdef MEM_ACCESS_MISALIGN_EN
    assign misalign      = misalign_q;
`else
    assign misalign      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model predicts every
// cycle's outputs while directed loads/stores run against a small word memory.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    typedef struct {
        logic        ready;
        logic        done;
        logic        rd;
        logic        wr;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [31:0] addr;
    } cyc_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'h0;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writeData;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [31:0]       mem_readData;

    logic [31:0] tb_mem [0:255] = '{default: 32'h0};
    logic [31:0] ref_mem [0:255];
    logic        preload_en = 1'b0;
    logic [7:0]  preload_idx = 8'h0;
    logic [31:0] preload_val = 32'h0;

    cyc_t        sched[$];
    cyc_t        cur;
    logic [31:0] model_rdata = 32'h0;
    bit          checking = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    int          last_done_edge = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    int          lat, rdc, wrc;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .we            (we),
        .size          (size),
        .sign_ext      (sign_ext),
        .addr          (addr),
        .wdata         (wdata),
        .ready         (ready),
        .done          (done),
        .rdata         (rdata),
        .misalign      (misalign),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_readData  (mem_readData)
    );

    always #5 clk = ~clk;

    // Little-endian word memory: combinational read, write on the clock edge.
    assign mem_readData = tb_mem[mem_address[9:2]];

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (preload_en) begin
            tb_mem[preload_idx] <= preload_val;
        end else if (mem_MemWrite) begin
            tb_mem[mem_address[9:2]] <= mem_writeData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sgn, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (word >> (8 * a[1:0])) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (word >> (16 * a[1])) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Every cycle while checking: the next scheduled cycle, or an idle cycle.
    always @(negedge clk) begin
        if (checking) begin
            if (sched.size() > 0) begin
                cur = sched.pop_front();
            end else begin
                cur = '{ready: 1'b1, done: 1'b0, rd: 1'b0, wr: 1'b0, mis: 1'b0,
                        rdata: model_rdata, wdata: 32'h0, addr: 32'h0};
            end
            checkOutput("ready", {31'h0, ready}, {31'h0, cur.ready});
            checkOutput("done", {31'h0, done}, {31'h0, cur.done});
            checkOutput("mem_MemRead", {31'h0, mem_MemRead}, {31'h0, cur.rd});
            checkOutput("mem_MemWrite", {31'h0, mem_MemWrite}, {31'h0, cur.wr});
            checkOutput("rdata", rdata, cur.rdata);
            if (cur.done) checkOutput("misalign", {31'h0, misalign}, {31'h0, cur.mis});
            if (cur.rd || cur.wr) checkOutput("mem_address", mem_address, cur.addr);
            if (cur.wr) checkOutput("mem_writeData", mem_writeData, cur.wdata);
            if (done) last_done_edge = cycle_cnt + 1;
            if (mem_MemRead) rd_total++;
            if (mem_MemWrite) wr_total++;
        end
    end

    task automatic applyStimulus(input logic we_i, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] wd, input bit abort_rd,
                                 output int latency, output int rd_cnt, output int wr_cnt);
        int          wait_cyc;
        int          accept_edge;
        int          rd_base;
        int          wr_base;
        logic        mis;
        logic [7:0]  idx;
        logic [31:0] old_word;
        logic [31:0] mask;
        logic [31:0] merged;
        cyc_t        r;

        wait_cyc = 0;
        @(posedge clk);
        #2;
        while (ready !== 1'b1 && wait_cyc < 20) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        if (ready !== 1'b1) checkOutput("ready_timeout", {31'h0, ready}, 32'h1);
        req = 1'b1; we = we_i; size = sz; sign_ext = sgn; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        accept_edge = cycle_cnt;
        rd_base = rd_total;
        wr_base = wr_total;

        idx = a[9:2];
        old_word = ref_mem[idx];
        mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_EN
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
        r = '{ready: 1'b0, done: 1'b0, rd: 1'b0, wr: 1'b0, mis: 1'b0,
              rdata: model_rdata, wdata: 32'h0, addr: {a[31:2], 2'b00}};
        if (mis) begin
            r.done = 1'b1; r.mis = 1'b1;
            sched.push_back(r);
        end else if (!we_i) begin
            r.rd = 1'b1;
            sched.push_back(r);
            model_rdata = model_load(old_word, sz, sgn, a);
            r.rd = 1'b0; r.done = 1'b1; r.rdata = model_rdata;
            sched.push_back(r);
        end else if (sz[1]) begin
            r.wr = 1'b1; r.wdata = wd;
            sched.push_back(r);
            ref_mem[idx] = wd;
            r.wr = 1'b0; r.done = 1'b1;
            sched.push_back(r);
        end else begin
            if (sz == 2'b00) begin
                mask = 32'hFF << (8 * a[1:0]);
                merged = (old_word & ~mask) | ((wd << (8 * a[1:0])) & mask);
            end else begin
                mask = 32'hFFFF << (16 * a[1]);
                merged = (old_word & ~mask) | ((wd << (16 * a[1])) & mask);
            end
            r.rd = 1'b1;
            sched.push_back(r);
            if (!abort_rd) begin
                r.rd = 1'b0; r.wr = 1'b1; r.wdata = merged;
                sched.push_back(r);
                ref_mem[idx] = merged;
                r.wr = 1'b0; r.done = 1'b1;
                sched.push_back(r);
            end
        end

        if (abort_rd) begin
            // Reset lands at the end of the RD cycle: no write, no done, back to idle.
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_rdata = 32'h0;
            checkOutput("abort_ready", {31'h0, ready}, 32'h1);
            checkOutput("abort_done", {31'h0, done}, 32'h0);
        end

        wait_cyc = 0;
        while (sched.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        #1;
        if (sched.size() > 0) begin
            checkOutput("txn_timeout", sched.size(), 32'h0);
            sched.delete();
        end
        latency = last_done_edge - accept_edge;
        rd_cnt = rd_total - rd_base;
        wr_cnt = wr_total - wr_base;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[8'h40] = 32'h8899AABB;
        ref_mem[8'hC0] = 32'h12345678;

        rst = 1'b1;
        preload_en = 1'b1;
        preload_idx = 8'h40; preload_val = 32'h8899AABB;
        @(posedge clk); #1;
        preload_idx = 8'hC0; preload_val = 32'h12345678;
        @(posedge clk); #1;
        preload_en = 1'b0;
        @(posedge clk); #1;

        checkOutput("reset_ready", {31'h0, ready}, 32'h1);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_misalign", {31'h0, misalign}, 32'h0);
        checkOutput("reset_memread", {31'h0, mem_MemRead}, 32'h0);
        checkOutput("reset_memwrite", {31'h0, mem_MemWrite}, 32'h0);
        checkOutput("reset_address", mem_address, 32'h0);
        rst = 1'b0;
        checking = 1'b1;

        applyStimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("lb_rdata", rdata, 32'hFFFFFFAA);
        checkOutput("lb_latency", lat, 32'd2);

        applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("lhu_rdata", rdata, 32'h00008899);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h103, 32'h11, 1'b0, lat, rdc, wrc);
        checkOutput("sb_mem", tb_mem[8'h40], 32'h1199AABB);
        checkOutput("sb_rd_cycles", rdc, 32'd1);
        checkOutput("sb_wr_cycles", wrc, 32'd1);
        checkOutput("sb_latency", lat, 32'd3);
        checkOutput("sb_rdata_kept", rdata, 32'h00008899);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, lat, rdc, wrc);
        checkOutput("sw_rd_cycles", rdc, 32'd0);
        checkOutput("sw_wr_cycles", wrc, 32'd1);
        checkOutput("sw_latency", lat, 32'd2);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("lw_rdata", rdata, 32'hDEADBEEF);

        applyStimulus(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("lbu_rdata", rdata, 32'h000000BB);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h202, 32'h0, 1'b0, lat, rdc, wrc);
`ifdef MEM_ACCESS_MISALIGN_EN
        checkOutput("mis_rdata_kept", rdata, 32'h000000BB);
        checkOutput("mis_latency", lat, 32'd1);
        checkOutput("mis_strobes", rdc + wrc, 32'd0);
`else
        checkOutput("unaligned_lw_rdata", rdata, 32'hDEADBEEF);
        checkOutput("unaligned_lw_latency", lat, 32'd2);
`endif

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000CAFE, 1'b0, lat, rdc, wrc);
        checkOutput("sh_mem", tb_mem[8'hC0], 32'hCAFE5678);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("lh_rdata", rdata, 32'hFFFFCAFE);

        applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("size11_rdata", rdata, 32'h1199AABB);

        applyStimulus(1'b1, 2'b01, 1'b0, 32'h300, 32'h0000BEEF, 1'b1, lat, rdc, wrc);
        checkOutput("abort_wr_cycles", wrc, 32'd0);
        checkOutput("abort_mem", tb_mem[8'hC0], 32'hCAFE5678);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, lat, rdc, wrc);
        checkOutput("after_abort_lw", rdata, 32'hCAFE5678);

        // Reset and request on the same edge: the request must be dropped.
        @(posedge clk); #2;
        rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h200;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        model_rdata = 32'h0;
        checkOutput("prio_ready", {31'h0, ready}, 32'h1);
        checkOutput("prio_rdata", rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        checkOutput("final_mem_100", tb_mem[8'h40], ref_mem[8'h40]);
        checkOutput("final_mem_200", tb_mem[8'h80], ref_mem[8'h80]);
        checkOutput("final_mem_300", tb_mem[8'hC0], ref_mem[8'hC0]);
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
